// File: rtl/path_sweep_ctrl.sv
// path_sweep_ctrl: steps {a,b,c,d} through all 16 vectors for the two-level
// AND datapath. Each vector is held for a settle window, then the datapath
// output is sampled once and checked against a&b&c&d.
//
// Control interface: start and abort are single-cycle level controls sampled
// on each rising edge; there is no ready/ack. start is honoured only in IDLE
// or DONE, and abort only while busy. When both are asserted in IDLE/DONE,
// start takes effect. done stays high until the next start or reset.
module path_sweep_ctrl #(
  parameter int SETTLE_CYC = 13,
  parameter int CNT_W      = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       dut_out,
  output logic [3:0] vec_out,
  output logic       busy,
  output logic       done,
  output logic       sample_strobe,
  output logic [4:0] err_count,
  output logic       err_flag,
  output logic [3:0] first_err_vec
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Counter reload value: SETTLE lasts cnt+1 cycles, counting down to zero.
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYC - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [3:0]       vec_next;
  logic             busy_next;
  logic             done_next;
  logic [4:0]       err_count_next;
  logic             err_flag_next;
  logic [3:0]       first_err_vec_next;

  // State register plus all registered outputs; reset overrides everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      vec_out       <= 4'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_count     <= 5'd0;
      err_flag      <= 1'b0;
      first_err_vec <= 4'd0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      vec_out       <= vec_next;
      busy          <= busy_next;
      done          <= done_next;
      err_count     <= err_count_next;
      err_flag      <= err_flag_next;
      first_err_vec <= first_err_vec_next;
    end
  end

  // Next-state and next-register-value logic for the sweep sequence.
  always_comb begin
    state_next         = state;
    cnt_next           = cnt;
    vec_next           = vec_out;
    busy_next          = busy;
    done_next          = done;
    err_count_next     = err_count;
    err_flag_next      = err_flag;
    first_err_vec_next = first_err_vec;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next         = SETTLE;
          cnt_next           = RELOAD;
          vec_next           = 4'd0;
          busy_next          = 1'b1;
          done_next          = 1'b0;
          err_count_next     = 5'd0;
          err_flag_next      = 1'b0;
          first_err_vec_next = 4'd0;
        end
      end

      SETTLE: begin
        if (abort) begin
          state_next = IDLE;
          vec_next   = 4'd0;
          busy_next  = 1'b0;
          done_next  = 1'b0;
        end else if (cnt == '0) begin
          state_next = SAMPLE;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end

      SAMPLE: begin
        if (abort) begin
          // An aborted sample is discarded; earlier error history is kept.
          state_next = IDLE;
          vec_next   = 4'd0;
          busy_next  = 1'b0;
          done_next  = 1'b0;
        end else begin
          // Written as match/else so an unknown dut_out lands in the error path.
          if (dut_out == (&vec_out)) begin
            err_count_next = err_count;
          end else begin
            if (err_count != 5'd16) begin
              err_count_next = err_count + 5'd1;
            end
            if (!err_flag) begin
              err_flag_next      = 1'b1;
              first_err_vec_next = vec_out;
            end
          end

          if (vec_out == 4'hF) begin
            state_next = DONE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end else begin
            state_next = SETTLE;
            vec_next   = vec_out + 4'd1;
            cnt_next   = RELOAD;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Unregistered output decode: strobe marks the single SAMPLE cycle.
  always_comb begin
    sample_strobe = (state == SAMPLE);
  end

endmodule

// File: tb/tb_path_sweep_ctrl.sv
// Bench for path_sweep_ctrl: main instance at SETTLE_CYC=3 with a behavioural
// datapath selected by mode, plus two instances driving a delayed two-level
// AND model to show the settle window margin.
module tb_path_sweep_ctrl;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // ---------------- main DUT ----------------
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       dut_out;
  logic [1:0] mode = 2'd0;
  logic [3:0] vec_out;
  logic       busy, done, sample_strobe;
  logic [4:0] err_count;
  logic       err_flag;
  logic [3:0] first_err_vec;

  // mode 0 ideal, 1 tied 0, 2 tied 1, 3 ideal with wrong answers on vectors 2 and 6
  assign dut_out = (mode == 2'd1) ? 1'b0 :
                   (mode == 2'd2) ? 1'b1 :
                   (mode == 2'd3) ? ((&vec_out) ^ ((vec_out == 4'd2) || (vec_out == 4'd6))) :
                   (&vec_out);

  path_sweep_ctrl #(.SETTLE_CYC(3), .CNT_W(8)) u_dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .dut_out(dut_out),
    .vec_out(vec_out), .busy(busy), .done(done), .sample_strobe(sample_strobe),
    .err_count(err_count), .err_flag(err_flag), .first_err_vec(first_err_vec)
  );

  // ---------------- settle-margin DUTs with delayed datapath ----------------
  logic       s_start = 1'b0;
  logic [3:0] s1_vec, s2_vec;
  logic       s1_busy, s1_done, s1_strobe, s1_flag;
  logic       s2_busy, s2_done, s2_strobe, s2_flag;
  logic [4:0] s1_err, s2_err;
  logic [3:0] s1_first, s2_first;
  logic       s1_ab = 1'b0, s1_cd = 1'b0, s1_out = 1'b0;
  logic       s2_ab = 1'b0, s2_cd = 1'b0, s2_out = 1'b0;

  // 13 time units per gate level, 10-unit clock period
  always @(s1_vec) begin
    s1_ab <= #13 s1_vec[3] & s1_vec[2];
    s1_cd <= #13 s1_vec[1] & s1_vec[0];
  end
  always @(s1_ab or s1_cd) s1_out <= #13 s1_ab & s1_cd;
  always @(s2_vec) begin
    s2_ab <= #13 s2_vec[3] & s2_vec[2];
    s2_cd <= #13 s2_vec[1] & s2_vec[0];
  end
  always @(s2_ab or s2_cd) s2_out <= #13 s2_ab & s2_cd;

  path_sweep_ctrl #(.SETTLE_CYC(1), .CNT_W(8)) u_s1 (
    .clock(clock), .reset(reset), .start(s_start), .abort(1'b0), .dut_out(s1_out),
    .vec_out(s1_vec), .busy(s1_busy), .done(s1_done), .sample_strobe(s1_strobe),
    .err_count(s1_err), .err_flag(s1_flag), .first_err_vec(s1_first)
  );

  path_sweep_ctrl #(.SETTLE_CYC(2), .CNT_W(8)) u_s2 (
    .clock(clock), .reset(reset), .start(s_start), .abort(1'b0), .dut_out(s2_out),
    .vec_out(s2_vec), .busy(s2_busy), .done(s2_done), .sample_strobe(s2_strobe),
    .err_count(s2_err), .err_flag(s2_flag), .first_err_vec(s2_first)
  );

  // ---------------- scoreboard ----------------
  logic [3:0] exp_q[$];
  int chk_cnt = 0;
  int pass_cnt = 0;
  int strobe_cnt = 0;

  // Each sample strobe must present the next expected vector.
  always @(negedge clock) begin
    if (sample_strobe === 1'b1) begin
      logic [3:0] exp_v;
      strobe_cnt++;
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_vec: strobe at vec_out=%h, expected none", vec_out);
      end else begin
        exp_v = exp_q.pop_front();
        if (vec_out !== exp_v) $display("FAIL sb_vec: vec_out=%h expected=%h", vec_out, exp_v);
        else pass_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input logic with_abort);
    @(negedge clock);
    start = 1'b1;
    abort = with_abort;
    @(negedge clock);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int v = lo; v <= hi; v++) exp_q.push_back(4'(v));
  endtask

  task automatic wait_done(input int limit, output int cycles);
    cycles = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic wait_vec(input logic [3:0] v);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (vec_out === v) begin
        found = 1'b1;
        break;
      end
    end
    chk_cnt++;
    if (!found) $display("FAIL wait_vec: vec_out=%h never reached %h", vec_out, v);
    else pass_cnt++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk_cnt++;
    if ({vec_out, busy, done, sample_strobe, err_count, err_flag, first_err_vec} !== 17'd0)
      $display("FAIL reset_outputs: got vec=%h busy=%b done=%b strobe=%b err=%0d flag=%b first=%h, required all 0",
               vec_out, busy, done, sample_strobe, err_count, err_flag, first_err_vec);
    else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_ideal_sweep;
    int cyc;
    mode = 2'd0;
    strobe_cnt = 0;
    push_range(0, 15);
    pulse_start(1'b0);
    chk_cnt++;
    if ({busy, done, vec_out} !== {1'b1, 1'b0, 4'h0})
      $display("FAIL ideal_start: busy=%b done=%b vec=%h, required 1 0 0", busy, done, vec_out);
    else pass_cnt++;
    wait_done(100, cyc);
    chk_cnt++;
    if (cyc != 64) $display("FAIL ideal_latency: %0d cycles, required 64", cyc);
    else pass_cnt++;
    chk_cnt++;
    if ({err_count, err_flag, busy, vec_out} !== {5'd0, 1'b0, 1'b0, 4'hF})
      $display("FAIL ideal_result: err=%0d flag=%b busy=%b vec=%h, required 0 0 0 f",
               err_count, err_flag, busy, vec_out);
    else pass_cnt++;
    chk_cnt++;
    if (strobe_cnt != 16 || exp_q.size() != 0)
      $display("FAIL ideal_strobes: strobes=%0d left=%0d, required 16 0", strobe_cnt, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_tied_zero;
    int cyc;
    mode = 2'd1;
    push_range(0, 15);
    pulse_start(1'b0);
    chk_cnt++;
    if ({done, busy} !== 2'b01) $display("FAIL restart_from_done: done=%b busy=%b, required 0 1", done, busy);
    else pass_cnt++;
    wait_done(100, cyc);
    chk_cnt++;
    if ({done, err_count, err_flag, first_err_vec} !== {1'b1, 5'd1, 1'b1, 4'hF})
      $display("FAIL tied0: done=%b err=%0d flag=%b first=%h, required 1 1 1 f",
               done, err_count, err_flag, first_err_vec);
    else pass_cnt++;
  endtask

  task automatic test_tied_one;
    int cyc;
    mode = 2'd2;
    push_range(0, 15);
    pulse_start(1'b1);
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL start_beats_abort: busy=%b, required 1", busy);
    else pass_cnt++;
    wait_done(100, cyc);
    chk_cnt++;
    if ({done, err_count, err_flag, first_err_vec} !== {1'b1, 5'd15, 1'b1, 4'h0})
      $display("FAIL tied1: done=%b err=%0d flag=%b first=%h, required 1 15 1 0",
               done, err_count, err_flag, first_err_vec);
    else pass_cnt++;
  endtask

  task automatic test_settle_margin;
    logic finished;
    finished = 1'b0;
    @(negedge clock);
    s_start = 1'b1;
    @(negedge clock);
    s_start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (s1_done === 1'b1 && s2_done === 1'b1) begin
        finished = 1'b1;
        break;
      end
    end
    chk_cnt++;
    if (!finished) $display("FAIL margin_done: s1_done=%b s2_done=%b, required 1 1", s1_done, s2_done);
    else pass_cnt++;
    chk_cnt++;
    if (s1_err === 5'd0) $display("FAIL margin_short: s1 err=%0d, required nonzero", s1_err);
    else pass_cnt++;
    chk_cnt++;
    if (s2_err !== 5'd0) $display("FAIL margin_long: s2 err=%0d, required 0", s2_err);
    else pass_cnt++;
  endtask

  task automatic test_abort;
    int cyc;
    mode = 2'd3;
    push_range(0, 4);
    pulse_start(1'b0);
    wait_vec(4'd3);
    pulse_start(1'b0);
    chk_cnt++;
    if ({busy, vec_out} !== {1'b1, 4'd3})
      $display("FAIL start_while_busy: busy=%b vec=%h, required 1 3", busy, vec_out);
    else pass_cnt++;
    wait_vec(4'd5);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk_cnt++;
    if ({vec_out, busy, done} !== {4'h0, 1'b0, 1'b0})
      $display("FAIL abort_state: vec=%h busy=%b done=%b, required 0 0 0", vec_out, busy, done);
    else pass_cnt++;
    chk_cnt++;
    if ({err_count, err_flag, first_err_vec} !== {5'd1, 1'b1, 4'h2})
      $display("FAIL abort_retain: err=%0d flag=%b first=%h, required 1 1 2", err_count, err_flag, first_err_vec);
    else pass_cnt++;
    repeat (3) @(negedge clock);
    chk_cnt++;
    if ({busy, vec_out, exp_q.size() == 0} !== {1'b0, 4'h0, 1'b1})
      $display("FAIL abort_idle: busy=%b vec=%h left=%0d, required 0 0 0", busy, vec_out, exp_q.size());
    else pass_cnt++;
    mode = 2'd0;
    push_range(0, 15);
    pulse_start(1'b0);
    chk_cnt++;
    if ({busy, vec_out, err_count, err_flag, first_err_vec} !== {1'b1, 4'h0, 5'd0, 1'b0, 4'h0})
      $display("FAIL abort_restart: busy=%b vec=%h err=%0d flag=%b first=%h, required 1 0 0 0 0",
               busy, vec_out, err_count, err_flag, first_err_vec);
    else pass_cnt++;
    wait_done(100, cyc);
    chk_cnt++;
    if (cyc != 64 || err_count !== 5'd0)
      $display("FAIL abort_rerun: cycles=%0d err=%0d, required 64 0", cyc, err_count);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_sweep;
    int cyc;
    mode = 2'd3;
    push_range(0, 8);
    pulse_start(1'b0);
    wait_vec(4'd9);
    chk_cnt++;
    if (err_count !== 5'd2) $display("FAIL mid_err: err=%0d, required 2", err_count);
    else pass_cnt++;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk_cnt++;
    if ({vec_out, busy, done, sample_strobe, err_count, err_flag, first_err_vec} !== 17'd0)
      $display("FAIL mid_reset: vec=%h busy=%b done=%b strobe=%b err=%0d flag=%b first=%h, required all 0",
               vec_out, busy, done, sample_strobe, err_count, err_flag, first_err_vec);
    else pass_cnt++;
    mode = 2'd0;
    strobe_cnt = 0;
    push_range(0, 15);
    pulse_start(1'b0);
    wait_done(100, cyc);
    chk_cnt++;
    if (cyc != 64 || strobe_cnt != 16 || err_count !== 5'd0 || exp_q.size() != 0)
      $display("FAIL post_reset_sweep: cycles=%0d strobes=%0d err=%0d left=%0d, required 64 16 0 0",
               cyc, strobe_cnt, err_count, exp_q.size());
    else pass_cnt++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_ideal_sweep();
    test_tied_zero();
    test_tied_one();
    test_settle_margin();
    test_abort();
    test_reset_mid_sweep();
    repeat (2) @(negedge clock);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt + 1);
    $fatal(1, "timeout");
  end

endmodule
